// File: rtl/sdram_soc_bridge_if.sv
// Bus bundle between a CPU-style valid/ready master, the bridge and the SDRAM controller.
// slave is the bridge's view; master is the view of whatever sits on the other side.
interface sdram_soc_bridge_if #(
  parameter int ADDR_WIDTH = 23
);
  logic                  mem_valid_pin;
  logic [31:0]           mem_addr_pin;
  logic [31:0]           mem_wdata_pin;
  logic [3:0]            mem_wstrb_pin;
  logic                  mem_ready_pin;
  logic [31:0]           mem_rdata_pin;
  logic                  mem_err_pin;
  logic                  ctrl_busy_pin;
  logic                  ctrl_ready_pin;
  logic [ADDR_WIDTH-1:0] ctrl_addr_pin;
  logic [31:0]           ctrl_wr_data_pin;
  logic [3:0]            ctrl_wr_mask_pin;
  logic                  ctrl_wr_en_pin;
  logic                  ctrl_rd_en_pin;
  logic [31:0]           ctrl_rd_data_pin;

  modport slave (
    input  mem_valid_pin, mem_addr_pin, mem_wdata_pin, mem_wstrb_pin,
    input  ctrl_busy_pin, ctrl_ready_pin, ctrl_rd_data_pin,
    output mem_ready_pin, mem_rdata_pin, mem_err_pin,
    output ctrl_addr_pin, ctrl_wr_data_pin, ctrl_wr_mask_pin, ctrl_wr_en_pin, ctrl_rd_en_pin
  );

  modport master (
    output mem_valid_pin, mem_addr_pin, mem_wdata_pin, mem_wstrb_pin,
    output ctrl_busy_pin, ctrl_ready_pin, ctrl_rd_data_pin,
    input  mem_ready_pin, mem_rdata_pin, mem_err_pin,
    input  ctrl_addr_pin, ctrl_wr_data_pin, ctrl_wr_mask_pin, ctrl_wr_en_pin, ctrl_rd_en_pin
  );
endinterface

// File: rtl/sdram_soc_bridge.sv
// Converts a valid/ready memory request into one SDRAM controller strobe/ready transaction,
// with window decode, byte-to-word address conversion and a completion timeout.
module sdram_soc_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'h2000_0000,
  parameter int          ADDR_WIDTH     = 23,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               reset_pin,
  sdram_soc_bridge_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                r_state, w_state;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [31:0]           r_wdata, w_wdata;
  logic [3:0]            r_mask, w_mask;
  logic                  r_isWrite, w_isWrite;
  logic                  r_wrEn, w_wrEn;
  logic                  r_rdEn, w_rdEn;
  logic                  r_memReady, w_memReady;
  logic [31:0]           r_memRdata, w_memRdata;
  logic                  r_memErr, w_memErr;
  logic                  w_inRange;
  logic [1:0]            w_unusedAddrLsb;

  assign w_inRange       = (bus.mem_addr_pin[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign w_unusedAddrLsb = bus.mem_addr_pin[1:0];

  // Next-state and next-output logic; every output is registered so the strobes and
  // the response pulse appear the cycle after the decision is made.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_mask     = r_mask;
    w_isWrite  = r_isWrite;
    w_wrEn     = 1'b0;
    w_rdEn     = 1'b0;
    w_memReady = 1'b0;
    w_memRdata = 32'h0;
    w_memErr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.mem_valid_pin) begin
          if (w_inRange) begin
            w_addr    = bus.mem_addr_pin[ADDR_WIDTH+1:2];
            w_wdata   = bus.mem_wdata_pin;
            w_mask    = bus.mem_wstrb_pin;
            w_isWrite = |bus.mem_wstrb_pin;
            w_state   = S_ISSUE;
          end else begin
            w_memReady = 1'b1;
            w_memErr   = 1'b1;
            w_state    = S_RESP;
          end
        end
      end
      // Busy may last through SDRAM init or refresh, so no timeout applies here.
      S_ISSUE: begin
        if (!bus.ctrl_busy_pin) begin
          w_wrEn  = r_isWrite;
          w_rdEn  = !r_isWrite;
          w_cnt   = '0;
          w_state = S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt = r_cnt + 1'b1;
        if (bus.ctrl_ready_pin) begin
          w_memReady = 1'b1;
          w_memRdata = r_isWrite ? 32'h0 : bus.ctrl_rd_data_pin;
          w_state    = S_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_memReady = 1'b1;
          w_memErr   = 1'b1;
          w_state    = S_RESP;
        end
      end
      S_RESP: begin
        w_cnt   = '0;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_pin) begin
    if (reset_pin) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_mask     <= 4'h0;
      r_isWrite  <= 1'b0;
      r_wrEn     <= 1'b0;
      r_rdEn     <= 1'b0;
      r_memReady <= 1'b0;
      r_memRdata <= 32'h0;
      r_memErr   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_mask     <= w_mask;
      r_isWrite  <= w_isWrite;
      r_wrEn     <= w_wrEn;
      r_rdEn     <= w_rdEn;
      r_memReady <= w_memReady;
      r_memRdata <= w_memRdata;
      r_memErr   <= w_memErr;
    end
  end

  assign bus.mem_ready_pin    = r_memReady;
  assign bus.mem_rdata_pin    = r_memRdata;
  assign bus.mem_err_pin      = r_memErr;
  assign bus.ctrl_addr_pin    = r_addr;
  assign bus.ctrl_wr_data_pin = r_wdata;
  assign bus.ctrl_wr_mask_pin = r_mask;
  assign bus.ctrl_wr_en_pin   = r_wrEn;
  assign bus.ctrl_rd_en_pin   = r_rdEn;

endmodule
